// File: rtl/spi_packet_slave_pkg.sv
// Shared constants and types for the SPI packet link.
// The spi_interface master uses the same frame widths.
//   META_W / PREFIX_W / DATA_W : field widths; a frame is meta, prefix, data, MSB first
//   FRAME_W                    : total bits per frame (328)
//   CNT_W / LAST_BIT           : bit counter width and the index of the final sclk rise
//   state_t                    : slave FSM state encoding
package spi_packet_slave_pkg;

  localparam int META_W   = 8;
  localparam int PREFIX_W = 64;
  localparam int DATA_W   = 256;
  localparam int FRAME_W  = META_W + PREFIX_W + DATA_W;

  localparam int CNT_W = 9;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_packet_slave_sync.sv
// Two-flop synchroniser with registered edge pulses for an asynchronous input.
//   clk  : system clock
//   rst  : asynchronous reset, active-low
//   din  : asynchronous input
//   rise : 1-clk pulse after a synchronised 0->1 transition
//   fall : 1-clk pulse after a synchronised 1->0 transition
// RST_VAL is the idle level of the input, so leaving reset does not fake an edge.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
      fall   <= ~sync_q & prev_q;
    end
  end

endmodule

// File: rtl/spi_packet_slave.sv
// SPI mode-0 slave endpoint for the packet link. Receives one 328-bit frame
// (meta, prefix, data, MSB first) into parallel outputs while shifting one
// locally queued TX frame (or zeros) out on miso.
//   clk, rst                  : system clock, asynchronous active-low reset
//   sclk, mosi, cs            : SPI from master (async; sclk <= clk/4; cs active-low)
//   miso                      : SPI data to master
//   RX_valid                  : 1-clk pulse, frame received; packet_* held until next frame
//   TX_valid / TX_ready       : offer / accept handshake for the TX holding register
//   TX_done                   : 1-clk pulse, pending TX frame fully shifted out
//   packet_*_input            : TX fields, sampled on accept
//
// state    | meaning
// ST_IDLE  | waiting for cs fall; miso low
// ST_SHIFT | frame in progress; sample on sclk rise, shift tx on sclk fall
// ST_DONE  | all bits received; extra sclk ignored until cs rise
module spi_packet_slave
  import spi_packet_slave_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs,
  output logic                miso,
  output logic                RX_valid,
  output logic [META_W-1:0]   packet_meta_data,
  output logic [PREFIX_W-1:0] packet_prefix,
  output logic [DATA_W-1:0]   packet_data,
  input  logic                TX_valid,
  output logic                TX_ready,
  output logic                TX_done,
  input  logic [META_W-1:0]   packet_meta_data_input,
  input  logic [PREFIX_W-1:0] packet_prefix_input,
  input  logic [DATA_W-1:0]   packet_data_input
);

  state_t           state, state_nxt;
  logic             sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic             mosi_meta, mosi_sync;
  logic [CNT_W-1:0] bitcnt;
  frame_t           rx_sr, tx_sr, tx_hold;
  logic             tx_pending, tx_sending, frame_end;
  logic             accept, last_rise, start;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst(rst), .din(cs), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  assign accept    = TX_valid & ~tx_pending;
  assign TX_ready  = ~tx_pending;
  assign start     = (state == ST_IDLE) & cs_fall;
  assign last_rise = (state == ST_SHIFT) & sclk_rise & (bitcnt == LAST_BIT);
  assign miso      = (state == ST_SHIFT) & tx_sr[FRAME_W-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // The final sclk rise wins over a coincident cs rise: the frame is complete.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cs_fall) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (last_rise)    state_nxt = ST_DONE;
        else if (cs_rise) state_nxt = ST_IDLE;
      end
      ST_DONE:  if (cs_rise) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bitcnt           <= '0;
      rx_sr            <= '0;
      tx_sr            <= '0;
      tx_hold          <= '0;
      tx_pending       <= 1'b0;
      tx_sending       <= 1'b0;
      frame_end        <= 1'b0;
      RX_valid         <= 1'b0;
      TX_done          <= 1'b0;
      packet_meta_data <= '0;
      packet_prefix    <= '0;
      packet_data      <= '0;
    end else begin
      frame_end <= last_rise;
      RX_valid  <= 1'b0;
      TX_done   <= 1'b0;

      // A frame accepted on the start cycle is not yet pending, so this
      // transaction sends zeros and the new frame waits for the next one.
      if (start) begin
        bitcnt     <= '0;
        tx_sr      <= tx_pending ? tx_hold : '0;
        tx_sending <= tx_pending;
      end else if (state == ST_SHIFT) begin
        if (sclk_rise) begin
          rx_sr <= {rx_sr[FRAME_W-2:0], mosi_sync};
          if (bitcnt != LAST_BIT) bitcnt <= bitcnt + CNT_W'(1);
        end
        if (sclk_fall) tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end

      if (frame_end) begin
        RX_valid         <= 1'b1;
        packet_meta_data <= rx_sr[FRAME_W-1 -: META_W];
        packet_prefix    <= rx_sr[DATA_W +: PREFIX_W];
        packet_data      <= rx_sr[DATA_W-1:0];
        if (tx_sending) begin
          TX_done    <= 1'b1;
          tx_sending <= 1'b0;
        end
      end

      if (accept) begin
        tx_hold    <= {packet_meta_data_input, packet_prefix_input, packet_data_input};
        tx_pending <= 1'b1;
      end else if (frame_end && tx_sending) begin
        tx_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_packet_slave.sv
module tb_spi_packet_slave;
  import spi_packet_slave_pkg::*;

  localparam int HP = 80;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                sclk = 1'b0;
  logic                mosi = 1'b0;
  logic                cs = 1'b1;
  logic                miso;
  logic                RX_valid;
  logic [META_W-1:0]   packet_meta_data;
  logic [PREFIX_W-1:0] packet_prefix;
  logic [DATA_W-1:0]   packet_data;
  logic                TX_valid = 1'b0;
  logic                TX_ready;
  logic                TX_done;
  logic [META_W-1:0]   packet_meta_data_input = '0;
  logic [PREFIX_W-1:0] packet_prefix_input = '0;
  logic [DATA_W-1:0]   packet_data_input = '0;

  int total = 0;
  int bad = 0;
  int rx_pulses = 0;
  int tx_pulses = 0;

  spi_packet_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso),
    .RX_valid(RX_valid), .packet_meta_data(packet_meta_data),
    .packet_prefix(packet_prefix), .packet_data(packet_data),
    .TX_valid(TX_valid), .TX_ready(TX_ready), .TX_done(TX_done),
    .packet_meta_data_input(packet_meta_data_input),
    .packet_prefix_input(packet_prefix_input),
    .packet_data_input(packet_data_input)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (RX_valid) rx_pulses++;
    if (TX_done)  tx_pulses++;
  end

  task automatic check(input string tag, input frame_t got, input frame_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic frame_t rx_out();
    return {packet_meta_data, packet_prefix, packet_data};
  endfunction

  task automatic load_tx(input frame_t f);
    packet_meta_data_input = f[FRAME_W-1 -: META_W];
    packet_prefix_input    = f[DATA_W +: PREFIX_W];
    packet_data_input      = f[DATA_W-1:0];
  endtask

  task automatic offer(input frame_t f);
    @(negedge clk);
    load_tx(f);
    TX_valid = 1'b1;
    @(negedge clk);
    TX_valid = 1'b0;
  endtask

  // Mode-0 master: mosi changes while sclk is low, miso sampled at sclk rise.
  // Bits past FRAME_W send 0 and are not recorded.
  task automatic xfer(input frame_t f, input int nbits, output frame_t rd);
    rd = '0;
    cs = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < FRAME_W) ? f[FRAME_W-1-i] : 1'b0;
      #HP;
      sclk = 1'b1;
      if (i < FRAME_W) rd[FRAME_W-1-i] = miso;
      #HP;
      sclk = 1'b0;
    end
    #HP;
    cs   = 1'b1;
    mosi = 1'b0;
    #(2*HP);
  endtask

  initial begin
    frame_t rd, f_rx, f_tx, b1, b2, fc, fd, fe, ff, fg, fh, fj;
    logic [DATA_W-1:0] here_data;
    int rx0, tx0;

    here_data = "here is data";
    f_rx = {8'b00101000, 64'd129, here_data};
    f_tx = {8'h5A, 64'hDEAD_BEEF, 256'h1};
    b1   = {8'hC3, 64'h0123_4567_89AB_CDEF, {8{32'hA5A5_0F0F}}};
    b2   = {8'h81, 64'hFFFF_0000_FFFF_0000, {4{64'h1357_9BDF_2468_ACE0}}};
    fc   = {8'h3C, 64'hCAFE_F00D_0000_0001, {8{32'h8000_0001}}};
    fd   = {8'h7E, 64'h1111_2222_3333_4444, {16{16'hBEEF}}};
    fe   = {8'hE1, 64'h5555_AAAA_5555_AAAA, 256'hF0};
    ff   = {8'hFF, {64{1'b1}}, {256{1'b1}}};
    fg   = {8'h96, 64'h0F0F_0F0F_0F0F_0F0F, {32{8'h69}}};
    fh   = {8'hAA, 64'h8888_7777_6666_5555, {8{32'h1234_5678}}};
    fj   = {8'h42, 64'h0000_0000_DEAD_0042, {8{32'hC001_D00D}}};

    // reset values
    #23;
    check("rst_miso", frame_t'(miso), '0);
    check("rst_rx_valid", frame_t'(RX_valid), '0);
    check("rst_tx_ready", frame_t'(TX_ready), frame_t'(1));
    check("rst_tx_done", frame_t'(TX_done), '0);
    check("rst_packet", rx_out(), '0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // receive only, no TX pending
    rx0 = rx_pulses; tx0 = tx_pulses;
    @(negedge clk);
    xfer(f_rx, FRAME_W, rd);
    check("rx_one_pulse", frame_t'(rx_pulses - rx0), frame_t'(1));
    check("rx_no_tx_done", frame_t'(tx_pulses - tx0), '0);
    check("rx_packet", rx_out(), f_rx);
    check("rx_miso_zero", rd, '0);
    repeat (20) @(negedge clk);
    check("rx_held", rx_out(), f_rx);

    // TX frame
    offer(f_tx);
    check("tx_ready_low", frame_t'(TX_ready), '0);
    rx0 = rx_pulses; tx0 = tx_pulses;
    @(negedge clk);
    xfer(b1, FRAME_W, rd);
    check("tx_miso", rd, f_tx);
    check("tx_done_pulse", frame_t'(tx_pulses - tx0), frame_t'(1));
    check("tx_ready_back", frame_t'(TX_ready), frame_t'(1));
    check("tx_rx_packet", rx_out(), b1);

    // back-to-back, TX only for the first
    offer(fc);
    rx0 = rx_pulses; tx0 = tx_pulses;
    @(negedge clk);
    xfer(b2, FRAME_W, rd);
    check("dup1_miso", rd, fc);
    check("dup1_rx", rx_out(), b2);
    @(negedge clk);
    xfer(b1, FRAME_W, rd);
    check("dup2_miso_zero", rd, '0);
    check("dup2_rx", rx_out(), b1);
    check("dup_rx_pulses", frame_t'(rx_pulses - rx0), frame_t'(2));
    check("dup_tx_pulses", frame_t'(tx_pulses - tx0), frame_t'(1));

    // abort after 100 rises, then retry
    offer(fd);
    rx0 = rx_pulses; tx0 = tx_pulses;
    @(negedge clk);
    xfer(b2, 100, rd);
    check("abort_no_rx", frame_t'(rx_pulses - rx0), '0);
    check("abort_no_tx_done", frame_t'(tx_pulses - tx0), '0);
    check("abort_tx_ready", frame_t'(TX_ready), '0);
    check("abort_rx_kept", rx_out(), b1);
    @(negedge clk);
    xfer(b2, FRAME_W, rd);
    check("retry_miso", rd, fd);
    check("retry_rx", rx_out(), b2);
    check("retry_pulses", frame_t'({rx_pulses - rx0, tx_pulses - tx0}), frame_t'({32'd1, 32'd1}));

    // busy: a second offer while pending is ignored; extra sclk after the frame ignored
    offer(fe);
    offer(ff);
    rx0 = rx_pulses;
    @(negedge clk);
    xfer(fg, FRAME_W + 2, rd);
    check("busy_miso", rd, fe);
    check("extra_sclk_rx", rx_out(), fg);
    check("extra_sclk_pulse", frame_t'(rx_pulses - rx0), frame_t'(1));
    check("busy_ready_back", frame_t'(TX_ready), frame_t'(1));

    // accept in the same clk as the cs-fall detect
    tx0 = tx_pulses;
    @(negedge clk);
    fork
      xfer(b1, FRAME_W, rd);
      begin
        #30;
        load_tx(fg);
        TX_valid = 1'b1;
        #10;
        TX_valid = 1'b0;
      end
    join
    check("race_miso_zero", rd, '0);
    check("race_no_tx_done", frame_t'(tx_pulses - tx0), '0);
    check("race_pending", frame_t'(TX_ready), '0);
    @(negedge clk);
    xfer(b2, FRAME_W, rd);
    check("race_next_miso", rd, fg);
    check("race_next_done", frame_t'(tx_pulses - tx0), frame_t'(1));

    // reset mid-frame at bit 200, then recovery
    offer(fh);
    rx0 = rx_pulses; tx0 = tx_pulses;
    @(negedge clk);
    fork
      xfer(b1, FRAME_W, rd);
      begin
        #(HP + 2*HP*200 + 33);
        rst = 1'b0;
        #1;
        check("mid_rst_miso", frame_t'(miso), '0);
        check("mid_rst_rx_valid", frame_t'(RX_valid), '0);
        check("mid_rst_tx_ready", frame_t'(TX_ready), frame_t'(1));
        check("mid_rst_packet", rx_out(), '0);
        #9;
        rst = 1'b1;
      end
    join
    check("mid_rst_no_pulses", frame_t'({rx_pulses - rx0, tx_pulses - tx0}), '0);
    @(negedge clk);
    xfer(fj, FRAME_W, rd);
    check("recover_rx", rx_out(), fj);
    check("recover_miso_zero", rd, '0);
    check("recover_pulses", frame_t'({rx_pulses - rx0, tx_pulses - tx0}), frame_t'({32'd1, 32'd0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
